// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared sizes and FSM encoding for the venus hazard controller.
// Build option: VENUS_HAZARD_BYPASS_EN (same-cycle writeback bypass).
package hazard_ctrl_pkg;

  localparam int HZ_NREG        = 16;
  localparam int HZ_NAME_W      = 4;
  localparam int HZ_STALL_LIMIT = 15;
  localparam int HZ_CNT_W       = 16;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard bundle between the pipeline and hazard_ctrl.
// master = pipeline side, slave = hazard_ctrl side.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int NAME_W = HZ_NAME_W,
  parameter int CNT_W  = HZ_CNT_W
);
  logic              id_v;
  logic [NAME_W-1:0] id_rd_name;
  logic [NAME_W-1:0] id_rs_name;
  logic              id_rd_use;
  logic              id_rs_use;
  logic              id_rd_reserve;
  logic              ex_wb;
  logic [NAME_W-1:0] ex_wb_rd_name;
  logic              ex_branch;
  logic              issue;
  logic              squash_id;
  logic              stall_idif;
  logic              stall_exid;
  logic              rd_busy;
  logic              rs_busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic              deadlock;

  modport master (
    output id_v, id_rd_name, id_rs_name,
    output id_rd_use, id_rs_use, id_rd_reserve,
    output ex_wb, ex_wb_rd_name, ex_branch,
    input  issue, squash_id, stall_idif, stall_exid,
    input  rd_busy, rs_busy, stall_cycles, deadlock
  );

  modport slave (
    input  id_v, id_rd_name, id_rs_name,
    input  id_rd_use, id_rs_use, id_rd_reserve,
    input  ex_wb, ex_wb_rd_name, ex_branch,
    output issue, squash_id, stall_idif, stall_exid,
    output rd_busy, rs_busy, stall_cycles, deadlock
  );

endinterface

// File: rtl/hazard_ctrl_busy_table.sv
// hazard_ctrl_busy_table: per-register write-in-flight bitmap, set wins over clear.
// VENUS_HAZARD_BYPASS_EN hides a bit on the cycle its writeback happens.
module hazard_ctrl_busy_table
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG   = HZ_NREG,
  parameter int NAME_W = HZ_NAME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic [NAME_W-1:0] i_set_name,
  input  logic              i_clr,
  input  logic [NAME_W-1:0] i_clr_name,
  input  logic [NAME_W-1:0] i_rd_a_name,
  input  logic [NAME_W-1:0] i_rd_b_name,
  output logic              o_busy_a,
  output logic              o_busy_b
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_eff;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    w_set_mask[i_set_name] = i_set;
    w_clr_mask[i_clr_name] = i_clr;
  end

`ifdef VENUS_HAZARD_BYPASS_EN
  assign w_eff = r_busy & ~w_clr_mask;
`else
  assign w_eff = r_busy;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_busy_a = w_eff[i_rd_a_name];
  assign o_busy_b = w_eff[i_rd_b_name];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID issue/stall/squash decision, stall counters and watchdog.
// Build option: VENUS_HAZARD_BYPASS_EN (handled inside the busy table).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG        = HZ_NREG,
  parameter int NAME_W      = HZ_NAME_W,
  parameter int STALL_LIMIT = HZ_STALL_LIMIT,
  parameter int CNT_W       = HZ_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_LIMIT - 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_deadlock;

  logic w_rd_busy;
  logic w_rs_busy;
  logic w_flush;
  logic w_hazard;
  logic w_issue;
  logic w_squash;
  logic w_stall_idif;

  hazard_ctrl_busy_table #(
    .NREG   (NREG),
    .NAME_W (NAME_W)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .i_set       (w_issue & hz.id_rd_reserve),
    .i_set_name  (hz.id_rd_name),
    .i_clr       (hz.ex_wb),
    .i_clr_name  (hz.ex_wb_rd_name),
    .i_rd_a_name (hz.id_rd_name),
    .i_rd_b_name (hz.id_rs_name),
    .o_busy_a    (w_rd_busy),
    .o_busy_b    (w_rs_busy)
  );

  assign w_flush  = (r_state == HZ_FLUSH);
  assign w_hazard = hz.id_v &
    (((hz.id_rd_use | hz.id_rd_reserve) & w_rd_busy) |
     (hz.id_rs_use & w_rs_busy));
  assign w_issue  = hz.id_v & ~w_hazard &
                    ~hz.ex_branch & ~w_flush;
  assign w_squash = hz.id_v & (hz.ex_branch | w_flush);
  assign w_stall_idif = w_hazard & ~w_squash;

  // A branch beats a hazard; a flush cycle always returns to RUN.
  always_comb begin
    w_state_nxt = HZ_RUN;
    if (hz.ex_branch) begin
      w_state_nxt = HZ_FLUSH;
    end else if (w_flush) begin
      w_state_nxt = HZ_RUN;
    end else if (w_hazard) begin
      w_state_nxt = HZ_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run       <= '0;
      r_stall_cnt <= '0;
      r_deadlock  <= 1'b0;
    end else begin
      if (w_stall_idif) begin
        if (r_run != RUN_MAX) begin
          r_run <= r_run + 1'b1;
        end
        if (r_run == RUN_TRIP) begin
          r_deadlock <= 1'b1;
        end
      end else begin
        r_run <= '0;
      end
      if (w_stall_idif && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // Outputs are held low for the whole reset cycle.
  assign hz.issue        = rst & w_issue;
  assign hz.squash_id    = rst & w_squash;
  assign hz.stall_idif   = rst & w_stall_idif;
  assign hz.stall_exid   = rst & (w_stall_idif | w_squash);
  assign hz.rd_busy      = rst & w_rd_busy;
  assign hz.rs_busy      = rst & w_rs_busy;
  assign hz.stall_cycles = rst ? r_stall_cnt : '0;
  assign hz.deadlock     = rst & r_deadlock;

endmodule
